// File: rtl/riscv_pkg.sv
// Shared definitions for the 3-stage RV32 core: field widths, the NOP
// encoding and the fetch->decode pipeline record.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic            valid;
    logic            fault;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear beats increment and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch->decode pipeline register. Holds on stall, injects a NOP bubble on
// flush (flush wins over stall), and counts stall/flush events.
module if_id_pipe_reg #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int              CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_f_i,
  input  logic [XLEN-1:0]  instr_f_i,
  input  logic [XLEN-1:0]  pc_f_i,
  input  logic [XLEN-1:0]  pc_plus_4_f_i,
  input  logic             fault_f_i,
  input  logic             cnt_clr_i,
  output logic             valid_d_o,
  output logic [XLEN-1:0]  instr_d_o,
  output logic [XLEN-1:0]  pc_d_o,
  output logic [XLEN-1:0]  pc_plus_4_d_o,
  output logic             fault_d_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  import riscv_pkg::*;

  if_id_t if_id_q;
  if_id_t if_id_d;
  logic   eff_stall_s;

  // A stall only counts when it is not overridden by a flush.
  assign eff_stall_s = stall_i & ~flush_i;

  // Next D-stage record: flush bubble, then hold, then normal load.
  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d.valid = 1'b0;
      if_id_d.fault = 1'b0;
      if_id_d.instr = NOP_INSTR;
      if_id_d.pc    = pc_f_i;          // kept for debug visibility
      if_id_d.pc4   = pc_plus_4_f_i;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else begin
      if_id_d.valid = valid_f_i;
      if_id_d.pc    = pc_f_i;
      if_id_d.pc4   = pc_plus_4_f_i;
      if (valid_f_i) begin
        if_id_d.instr = instr_f_i;
        if_id_d.fault = fault_f_i;
      end else begin
        if_id_d.instr = NOP_INSTR;
        if_id_d.fault = 1'b0;
      end
    end
  end

  // D-stage register; reset loads a NOP with everything else cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_q.valid <= 1'b0;
      if_id_q.fault <= 1'b0;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= {XLEN{1'b0}};
      if_id_q.pc4   <= {XLEN{1'b0}};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign valid_d_o     = if_id_q.valid;
  assign fault_d_o     = if_id_q.fault;
  assign instr_d_o     = if_id_q.instr;
  assign pc_d_o        = if_id_q.pc;
  assign pc_plus_4_d_o = if_id_q.pc4;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (eff_stall_s),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg. A 16-bit-counter instance and a
// 4-bit-counter instance share the same stimulus.
module tb_if_id_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_f_i, fault_f_i, cnt_clr_i;
  logic [31:0] instr_f_i, pc_f_i, pc_plus_4_f_i;

  logic        valid_d_o, fault_d_o;
  logic [31:0] instr_d_o, pc_d_o, pc_plus_4_d_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        valid4_o, fault4_o;
  logic [31:0] instr4_o, pc4_o, pcp4_4_o;
  logic [3:0]  stall_cnt4_o, flush_cnt4_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_f_i(valid_f_i), .instr_f_i(instr_f_i), .pc_f_i(pc_f_i),
    .pc_plus_4_f_i(pc_plus_4_f_i), .fault_f_i(fault_f_i), .cnt_clr_i(cnt_clr_i),
    .valid_d_o(valid_d_o), .instr_d_o(instr_d_o), .pc_d_o(pc_d_o),
    .pc_plus_4_d_o(pc_plus_4_d_o), .fault_d_o(fault_d_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_id_pipe_reg #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_f_i(valid_f_i), .instr_f_i(instr_f_i), .pc_f_i(pc_f_i),
    .pc_plus_4_f_i(pc_plus_4_f_i), .fault_f_i(fault_f_i), .cnt_clr_i(cnt_clr_i),
    .valid_d_o(valid4_o), .instr_d_o(instr4_o), .pc_d_o(pc4_o),
    .pc_plus_4_d_o(pcp4_4_o), .fault_d_o(fault4_o),
    .stall_cnt_o(stall_cnt4_o), .flush_cnt_o(flush_cnt4_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock edge; inputs may change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic flt);
    valid_f_i     = v;
    instr_f_i     = ins;
    pc_f_i        = pc;
    pc_plus_4_f_i = pc + 32'd4;
    fault_f_i     = flt;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
    drive_f(1'b1, 32'hFFFF_FFFF, 32'h0000_0500, 1'b1);
    step(); step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !== {1'b0, 1'b0, NOP, 32'd0, 32'd0})
      $display("FAIL reset_dp: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=0 f=0 instr=%h pc=0 pc4=0",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o, NOP);
    else pass_cnt++;
    total_cnt++;
    if ({stall_cnt_o, flush_cnt_o} !== 32'd0)
      $display("FAIL reset_cnt: stall=%0d flush=%0d expected 0/0", stall_cnt_o, flush_cnt_o);
    else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_load();
    drive_f(1'b1, 32'h00A0_0093, 32'h0000_0100, 1'b0);
    step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !==
        {1'b1, 1'b0, 32'h00A0_0093, 32'h0000_0100, 32'h0000_0104})
      $display("FAIL load: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=1 f=0 instr=00a00093 pc=00000100 pc4=00000104",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_f(1'b1, 32'h1111_0000 + i, 32'h0000_0100 + 32'(4 * i), 1'b1);
      step();
      total_cnt++;
      if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !==
          {1'b1, 1'b0, 32'h00A0_0093, 32'h0000_0100, 32'h0000_0104})
        $display("FAIL stall_hold%0d: instr=%h pc=%h pc4=%h f=%0b expected instr=00a00093 pc=00000100 pc4=00000104 f=0",
                 i, instr_d_o, pc_d_o, pc_plus_4_d_o, fault_d_o);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_cnt_o !== 16'd3 || stall_cnt4_o !== 4'd3)
      $display("FAIL stall_cnt: %0d/%0d expected 3/3", stall_cnt_o, stall_cnt4_o);
    else pass_cnt++;
    stall_i = 1'b0;
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    drive_f(1'b1, 32'h1234_5678, 32'h0000_0110, 1'b1);
    step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !==
        {1'b0, 1'b0, NOP, 32'h0000_0110, 32'h0000_0114})
      $display("FAIL flush: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=0 f=0 instr=00000013 pc=00000110 pc4=00000114",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o);
    else pass_cnt++;
    total_cnt++;
    if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd3)
      $display("FAIL flush_cnt: flush=%0d stall=%0d expected 1/3", flush_cnt_o, stall_cnt_o);
    else pass_cnt++;
    flush_i = 1'b0;
  endtask

  task automatic test_valid_fault();
    drive_f(1'b0, 32'hDEAD_BEEF, 32'h0000_0200, 1'b1);
    step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !==
        {1'b0, 1'b0, NOP, 32'h0000_0200, 32'h0000_0204})
      $display("FAIL invalid_f: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=0 f=0 instr=00000013 pc=00000200 pc4=00000204",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o);
    else pass_cnt++;
    drive_f(1'b1, 32'hCAFE_0033, 32'hFFFF_FFFC, 1'b1);
    step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !==
        {1'b1, 1'b1, 32'hCAFE_0033, 32'hFFFF_FFFC, 32'h0000_0000})
      $display("FAIL fault_load: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=1 f=1 instr=cafe0033 pc=fffffffc pc4=00000000",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o);
    else pass_cnt++;
  endtask

  task automatic test_stall_and_flush();
    stall_i = 1'b1; flush_i = 1'b1;
    drive_f(1'b1, 32'h0000_00B3, 32'h0000_0300, 1'b1);
    step();
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o} !== {1'b0, 1'b0, NOP, 32'h0000_0300})
      $display("FAIL stall_flush_bubble: v=%0b f=%0b instr=%h pc=%h expected v=0 f=0 instr=00000013 pc=00000300",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o);
    else pass_cnt++;
    total_cnt++;
    if (flush_cnt_o !== 16'd2 || stall_cnt_o !== 16'd3)
      $display("FAIL stall_flush_cnt: flush=%0d stall=%0d expected 2/3", flush_cnt_o, stall_cnt_o);
    else pass_cnt++;
    stall_i = 1'b0; flush_i = 1'b0;
    drive_f(1'b1, 32'h0000_0513, 32'h0000_0400, 1'b0);
    step();
  endtask

  task automatic test_saturate_clear();
    stall_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total_cnt++;
    if (stall_cnt4_o !== 4'd15 || stall_cnt_o !== 16'd23)
      $display("FAIL stall_sat: cnt4=%0d cnt16=%0d expected 15/23", stall_cnt4_o, stall_cnt_o);
    else pass_cnt++;
    cnt_clr_i = 1'b1;
    step();
    total_cnt++;
    if ({stall_cnt4_o, flush_cnt4_o, stall_cnt_o, flush_cnt_o} !== 40'd0)
      $display("FAIL clr: s4=%0d f4=%0d s16=%0d f16=%0d expected all 0",
               stall_cnt4_o, flush_cnt4_o, stall_cnt_o, flush_cnt_o);
    else pass_cnt++;
    total_cnt++;
    if ({valid_d_o, instr_d_o, pc_d_o} !== {1'b1, 32'h0000_0513, 32'h0000_0400})
      $display("FAIL clr_dp_hold: v=%0b instr=%h pc=%h expected v=1 instr=00000513 pc=00000400",
               valid_d_o, instr_d_o, pc_d_o);
    else pass_cnt++;
    cnt_clr_i = 1'b0;
    step();
    total_cnt++;
    if (stall_cnt4_o !== 4'd1 || stall_cnt_o !== 16'd1)
      $display("FAIL post_clr_inc: cnt4=%0d cnt16=%0d expected 1/1", stall_cnt4_o, stall_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    stall_i = 1'b1;
    step();
    #2;
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o} !== {1'b0, 1'b0, NOP, 32'd0, 32'd0})
      $display("FAIL async_rst_dp: v=%0b f=%0b instr=%h pc=%h pc4=%h expected v=0 f=0 instr=00000013 pc=0 pc4=0",
               valid_d_o, fault_d_o, instr_d_o, pc_d_o, pc_plus_4_d_o);
    else pass_cnt++;
    total_cnt++;
    if ({stall_cnt_o, flush_cnt_o, stall_cnt4_o} !== 36'd0)
      $display("FAIL async_rst_cnt: stall=%0d flush=%0d stall4=%0d expected 0",
               stall_cnt_o, flush_cnt_o, stall_cnt4_o);
    else pass_cnt++;
    step();
    rst_i = 1'b0; stall_i = 1'b0;
    drive_f(1'b1, 32'h0040_0113, 32'h0000_0600, 1'b0);
    step();
    total_cnt++;
    if ({valid_d_o, instr_d_o, pc_d_o} !== {1'b1, 32'h0040_0113, 32'h0000_0600})
      $display("FAIL post_rst_load: v=%0b instr=%h pc=%h expected v=1 instr=00400113 pc=00000600",
               valid_d_o, instr_d_o, pc_d_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_valid_fault();
    test_stall_and_flush();
    test_saturate_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
